// File: rtl/noc_out_arbiter_pkg.sv
// Shared NoC types: packet layout, link byte ordering, arbiter states.
// Used by nodes, router ports and noc_out_arbiter.
package noc_out_arbiter_pkg;

  localparam int PKT_BYTES = 4;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [23:0] data;
  } pkt_t;

  typedef logic [PKT_BYTES-1:0][7:0] pkt_bytes_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte 0 carries the route header; data follows MSB first.
  function automatic pkt_bytes_t pkt_to_bytes(input pkt_t p);
    pkt_bytes_t b;
    b[0] = {p.src, p.dst};
    b[1] = p.data[23:16];
    b[2] = p.data[15:8];
    b[3] = p.data[7:0];
    return b;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr.
// Emits a one-hot grant and the winner index.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0] w_j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    w_j = '0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, ptr} + (W+1)'(k);
      if (w_j >= (W+1)'(N)) begin
        w_j = w_j - (W+1)'(N);
      end
      if (!any && req[w_j[W-1:0]]) begin
        any             = 1'b1;
        gnt[w_j[W-1:0]] = 1'b1;
        idx             = w_j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Round-robin output-link arbiter; serializes one packet as 4 link bytes.
// Define NOC_ARB_STATS_EN to add per-source saturating grant counters.
module noc_out_arbiter
  import noc_out_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int W       = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic [NUM_REQ-1:0] req,
  input  pkt_t               pkt_in [NUM_REQ],
  output logic [NUM_REQ-1:0] grant,
  input  logic               free_out,
  output logic               put_out,
  output logic [7:0]         payload_out,
  output logic               busy
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt [NUM_REQ]
`endif
);

  localparam logic [2:0] LAST = 3'(PKT_BYTES);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_ptr;
  logic [2:0]         r_cnt;
  pkt_bytes_t         r_hold;
  logic               r_put;
  logic [7:0]         r_payload;
  logic [NUM_REQ-1:0] w_gnt;
  logic [W-1:0]       w_idx;
  logic               w_any;
  logic               w_fire;
  pkt_bytes_t         w_bytes;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req(req),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_idx),
    .any(w_any)
  );

  assign w_fire  = (r_state == IDLE) && free_out && w_any;
  assign w_bytes = pkt_to_bytes(pkt_in[w_idx]);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_fire) w_next = SEND;
      SEND: if (r_cnt == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    grant = w_fire ? w_gnt : '0;
    busy  = (r_state == SEND);
  end

  // r_cnt indexes the next byte to show; LAST means byte3 is on the link.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_put     <= 1'b0;
      r_payload <= 8'h00;
    end else if (w_fire) begin
      r_hold    <= w_bytes;
      r_ptr     <= (w_idx == W'(NUM_REQ-1)) ? '0 : w_idx + W'(1);
      r_put     <= 1'b1;
      r_payload <= w_bytes[0];
      r_cnt     <= 3'd1;
    end else if (r_state == SEND) begin
      if (r_cnt == LAST) begin
        r_put <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_payload <= r_hold[r_cnt[1:0]];
        r_cnt     <= r_cnt + 3'd1;
      end
    end
  end

  assign put_out     = r_put;
  assign payload_out = r_payload;

`ifdef NOC_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter: arbitration order, link timing,
// back-pressure, non-interruptible packets and mid-packet reset.
module tb_noc_out_arbiter;
  import noc_out_arbiter_pkg::*;

  logic       clock;
  logic       reset_b;
  logic [3:0] req;
  pkt_t       pkt_in [4];
  logic [3:0] grant;
  logic       free_out;
  logic       put_out;
  logic [7:0] payload_out;
  logic       busy;
`ifdef NOC_ARB_STATS_EN
  logic [15:0] grant_cnt [4];
`endif

  int errs;
  int checks;

  noc_out_arbiter #(
    .NUM_REQ(4)
  ) dut (
    .clock(clock),
    .reset_b(reset_b),
    .req(req),
    .pkt_in(pkt_in),
    .grant(grant),
    .free_out(free_out),
    .put_out(put_out),
    .payload_out(payload_out),
    .busy(busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int s, input int k);
    logic [7:0] b;
    case (k)
      0:       b = {4'(s), 4'(s + 4)};
      1:       b = 8'(160 + s);
      2:       b = 8'(176 + s);
      default: b = 8'(192 + s);
    endcase
    return b;
  endfunction

  task automatic set_default;
    for (int i = 0; i < 4; i++) begin
      pkt_in[i] = {4'(i), 4'(i + 4), 8'(160 + i), 8'(176 + i), 8'(192 + i)};
    end
  endtask

  task automatic do_reset;
    req      = '0;
    reset_b  = 1'b0;
    #1;
    reset_b  = 1'b1;
    tick();
  endtask

  task automatic drain(input logic [3:0] r);
    tick();
    req = r;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    reset_b  = 1'b0;
    req      = '0;
    free_out = 1'b0;
    set_default();
    #2;
    checks++;
    if (put_out !== 1'b0 || payload_out !== 8'h00 || busy !== 1'b0 ||
        grant !== 4'b0000) begin
      errs++;
      $display("FAIL reset: put=%b pay=%h busy=%b grant=%b want 0 00 0 0000",
               put_out, payload_out, busy, grant);
    end
    #10;
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [7:0] want [4];
    want[0] = 8'h12; want[1] = 8'hAB; want[2] = 8'hCD; want[3] = 8'hEF;
    req       = 4'b0001;
    pkt_in[0] = {4'd1, 4'd2, 24'hABCDEF};
    free_out  = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_grant: grant=%b busy=%b want 0001 0", grant, busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      req = '0;
      #1;
      checks++;
      if (put_out !== 1'b1 || payload_out !== want[k] || busy !== 1'b1 ||
          grant !== 4'b0000) begin
        errs++;
        $display("FAIL single_byte%0d: put=%b pay=%h busy=%b grant=%b want 1 %h 1 0000",
                 k, put_out, payload_out, busy, grant, want[k]);
      end
    end
    tick();
    #1;
    checks++;
    if (put_out !== 1'b0 || payload_out !== 8'hEF || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_end: put=%b pay=%h busy=%b want 0 ef 0",
               put_out, payload_out, busy);
    end
    set_default();
  endtask

  task automatic test_round_robin;
    int         m;
    int         g;
    logic [3:0] eg;
    do_reset();
    free_out = 1'b1;
    for (int c = 0; c < 24; c++) begin
      req = 4'b1111;
      #1;
      m  = c % 5;
      g  = c / 5;
      eg = (m == 0) ? 4'(1 << (g % 4)) : 4'b0000;
      checks++;
      if (grant !== eg || put_out !== (m != 0)) begin
        errs++;
        $display("FAIL rr_cycle%0d: grant=%b put=%b want %b %b",
                 c, grant, put_out, eg, (m != 0));
      end
      if (m != 0) begin
        checks++;
        if (payload_out !== exp_byte((g % 4), m - 1)) begin
          errs++;
          $display("FAIL rr_payload%0d: got %h want %h",
                   c, payload_out, exp_byte((g % 4), m - 1));
        end
      end
      tick();
    end
    req = '0;
    #1;
    checks++;
    if (put_out !== 1'b1 || payload_out !== exp_byte(0, 3)) begin
      errs++;
      $display("FAIL rr_last: put=%b pay=%h want 1 %h",
               put_out, payload_out, exp_byte(0, 3));
    end
`ifdef NOC_ARB_STATS_EN
    checks++;
    if (grant_cnt[0] !== 16'd2 || grant_cnt[1] !== 16'd1 ||
        grant_cnt[2] !== 16'd1 || grant_cnt[3] !== 16'd1) begin
      errs++;
      $display("FAIL rr_stats: %0d %0d %0d %0d want 2 1 1 1",
               grant_cnt[0], grant_cnt[1], grant_cnt[2], grant_cnt[3]);
    end
`endif
    tick();
    tick();
  endtask

  task automatic test_ptr_skip;
    do_reset();
    free_out = 1'b1;
    req      = 4'b0010;
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errs++;
      $display("FAIL ptr_first: grant=%b want 0010", grant);
    end
    drain(4'b0000);
    req = 4'b0011;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errs++;
      $display("FAIL ptr_wrap: grant=%b want 0001", grant);
    end
    drain(4'b0011);
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errs++;
      $display("FAIL ptr_next: grant=%b want 0010", grant);
    end
    drain(4'b0000);
  endtask

  task automatic test_free_low;
    free_out = 1'b0;
    req      = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000 || put_out !== 1'b0) begin
        errs++;
        $display("FAIL free_low%0d: grant=%b put=%b want 0000 0",
                 c, grant, put_out);
      end
      tick();
    end
    free_out = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0100) begin
      errs++;
      $display("FAIL free_rise: grant=%b want 0100", grant);
    end
    drain(4'b0000);
  endtask

  task automatic test_no_interrupt;
    free_out = 1'b1;
    req      = 4'b1000;
    #1;
    checks++;
    if (grant !== 4'b1000) begin
      errs++;
      $display("FAIL noint_grant: grant=%b want 1000", grant);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        req = '0;
      end else begin
        free_out = 1'b0;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) pkt_in[i] = 32'hDEADBEEF;
      end
      #1;
      checks++;
      if (put_out !== 1'b1 || payload_out !== exp_byte(3, k) ||
          grant !== 4'b0000) begin
        errs++;
        $display("FAIL noint_byte%0d: put=%b pay=%h grant=%b want 1 %h 0000",
                 k, put_out, payload_out, grant, exp_byte(3, k));
      end
    end
    tick();
    #1;
    checks++;
    if (put_out !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      errs++;
      $display("FAIL noint_end: put=%b grant=%b busy=%b want 0 0000 0",
               put_out, grant, busy);
    end
    req      = '0;
    free_out = 1'b1;
    set_default();
    tick();
  endtask

  task automatic test_reset_mid;
    free_out = 1'b1;
    req      = 4'b0100;
    #1;
    checks++;
    if (grant !== 4'b0100) begin
      errs++;
      $display("FAIL rmid_grant: grant=%b want 0100", grant);
    end
    tick();
    req = '0;
    tick();
    tick();
    #1;
    checks++;
    if (put_out !== 1'b1 || payload_out !== exp_byte(2, 2)) begin
      errs++;
      $display("FAIL rmid_byte2: put=%b pay=%h want 1 %h",
               put_out, payload_out, exp_byte(2, 2));
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if (put_out !== 1'b0 || payload_out !== 8'h00 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rmid_abort: put=%b pay=%h busy=%b want 0 00 0",
               put_out, payload_out, busy);
    end
`ifdef NOC_ARB_STATS_EN
    checks++;
    if (grant_cnt[0] !== 16'd0 || grant_cnt[1] !== 16'd0 ||
        grant_cnt[2] !== 16'd0 || grant_cnt[3] !== 16'd0) begin
      errs++;
      $display("FAIL rmid_stats: %0d %0d %0d %0d want all 0",
               grant_cnt[0], grant_cnt[1], grant_cnt[2], grant_cnt[3]);
    end
`endif
    reset_b = 1'b1;
    tick();
    req = 4'b1111;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errs++;
      $display("FAIL rmid_restart: grant=%b want 0001", grant);
    end
    drain(4'b0000);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_skip();
    test_free_low();
    test_no_interrupt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
